ultrasonic_scheduler: RTL and testbench

Round-robin controller for up to N HC-SR04-style ultrasonic sensors sharing one measurement engine. Sequences each sensor through trigger, echo wait, echo-width measurement and guard gap. Converts echo width to whole centimetres and emits one result strobe per sensor per scan. Sits between the sensor header pins and the display/readout logic.

---
 rtl/us_sched_pkg.sv | 16 +
 rtl/us_echo_timer.sv | 50 +++++
 rtl/ultrasonic_scheduler.sv | 178 +++++++++++++++++
 tb/tb_ultrasonic_scheduler.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/us_sched_pkg.sv
// Shared types and constants for the ultrasonic sensor scheduler.
package us_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        GAP
    } state_t;

    typedef logic [7:0] dist_t;

    localparam dist_t DIST_MAX = 8'd255;

endpackage

// File: rtl/us_echo_timer.sv
// Echo edge detector plus tick divider and saturating centimetre counter.
module us_echo_timer
    import us_sched_pkg::*;
#(
    parameter int TICK_DIV = 2900
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  clear,
    input  logic  echo_s,
    output dist_t cm,
    output logic  overflow,
    output logic  rise,
    output logic  fall
);

    localparam int TW = $clog2(TICK_DIV + 1);

    logic [TW-1:0] tick;
    logic          echo_d;
    logic          wrap;

    assign rise     = echo_s & ~echo_d;
    assign fall     = ~echo_s & echo_d;
    assign wrap     = ~clear & echo_s & (tick == TW'(TICK_DIV - 1));
    // Overflow fires on the wrap that would take cm past its ceiling.
    assign overflow = wrap & (cm == DIST_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            echo_d <= 1'b0;
            tick   <= '0;
            cm     <= '0;
        end else begin
            echo_d <= echo_s;
            if (clear) begin
                tick <= '0;
                cm   <= '0;
            end else if (echo_s) begin
                if (wrap) begin
                    tick <= '0;
                    if (cm != DIST_MAX) cm <= cm + 8'd1;
                end else begin
                    tick <= tick + TW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/ultrasonic_scheduler.sv
// Round-robin scheduler for HC-SR04-style sensors sharing one echo timer.
// Optional per-sensor skip mask: define ULTRASONIC_MASK_EN.
module ultrasonic_scheduler
    import us_sched_pkg::*;
#(
    parameter int N_SENSORS    = 4,
    parameter int TRIG_CYCLES  = 500,
    parameter int TICK_DIV     = 2900,
    parameter int RISE_TIMEOUT = 1_500_000,
    parameter int GAP_CYCLES   = 3_000_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
`ifdef ULTRASONIC_MASK_EN
    input  logic [N_SENSORS-1:0] sensor_mask,
`endif
    input  logic                 start,
    input  logic                 continuous,
    input  logic [N_SENSORS-1:0] echo,
    output logic [N_SENSORS-1:0] trig,
    output dist_t                dist_value,
    output logic [2:0]           dist_idx,
    output logic                 dist_err,
    output logic                 dist_valid,
    output logic                 busy
);

    localparam int CNT_A   = (TRIG_CYCLES > RISE_TIMEOUT) ? TRIG_CYCLES : RISE_TIMEOUT;
    localparam int CNT_MAX = (CNT_A > GAP_CYCLES) ? CNT_A : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t               state;
    logic [2:0]           idx;
    logic [CNT_W-1:0]     cnt;
    logic [N_SENSORS-1:0] echo_m, echo_s;
    logic [7:0]           echo_pad, mask8;
    logic [2:0]           first_idx, next_idx;
    logic                 has_first, has_next;
    logic                 sel_echo, clear, rise, fall, overflow;
    dist_t                cm;

    function automatic logic [N_SENSORS-1:0] onehot(input logic [2:0] i);
        logic [7:0] t;
        t = 8'd1 << i;
        return N_SENSORS'(t);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            echo_m <= '0;
            echo_s <= '0;
        end else begin
            echo_m <= echo;
            echo_s <= echo_m;
        end
    end

    assign echo_pad = 8'(echo_s);
    assign sel_echo = echo_pad[idx];
    assign busy     = (state != IDLE);

`ifdef ULTRASONIC_MASK_EN
    assign mask8 = 8'(sensor_mask);
`else
    assign mask8 = 8'((1 << N_SENSORS) - 1);
`endif

    // Lowest enabled sensor overall, and lowest enabled sensor above idx.
    always_comb begin
        has_first = 1'b0;
        first_idx = 3'd0;
        has_next  = 1'b0;
        next_idx  = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask8[i]) begin
                has_first = 1'b1;
                first_idx = 3'(i);
                if (i > int'(idx)) begin
                    has_next = 1'b1;
                    next_idx = 3'(i);
                end
            end
        end
    end

    // Counters run only while measuring, starting on the detected rise.
    assign clear = !((state == MEASURE) || ((state == WAIT_RISE) && rise));

    us_echo_timer #(.TICK_DIV(TICK_DIV)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .echo_s   (sel_echo),
        .cm       (cm),
        .overflow (overflow),
        .rise     (rise),
        .fall     (fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= 3'd0;
            cnt        <= '0;
            trig       <= '0;
            dist_value <= '0;
            dist_idx   <= 3'd0;
            dist_err   <= 1'b0;
            dist_valid <= 1'b0;
        end else begin
            dist_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && has_first) begin
                        idx   <= first_idx;
                        trig  <= onehot(first_idx);
                        cnt   <= '0;
                        state <= TRIG;
                    end
                end
                TRIG: begin
                    if (cnt == CNT_W'(TRIG_CYCLES - 1)) begin
                        trig  <= '0;
                        cnt   <= '0;
                        state <= WAIT_RISE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WAIT_RISE: begin
                    if (rise) begin
                        cnt   <= '0;
                        state <= MEASURE;
                    end else if (cnt == CNT_W'(RISE_TIMEOUT - 1)) begin
                        dist_value <= DIST_MAX;
                        dist_err   <= 1'b1;
                        dist_idx   <= idx;
                        dist_valid <= 1'b1;
                        cnt        <= '0;
                        state      <= GAP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                MEASURE: begin
                    if (fall || overflow) begin
                        dist_value <= fall ? cm : DIST_MAX;
                        dist_err   <= ~fall;
                        dist_idx   <= idx;
                        dist_valid <= 1'b1;
                        cnt        <= '0;
                        state      <= GAP;
                    end
                end
                GAP: begin
                    if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
                        cnt <= '0;
                        if (has_next) begin
                            idx   <= next_idx;
                            trig  <= onehot(next_idx);
                            state <= TRIG;
                        end else if (continuous && has_first) begin
                            idx   <= first_idx;
                            trig  <= onehot(first_idx);
                            state <= TRIG;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ultrasonic_scheduler.sv
// Directed bench for ultrasonic_scheduler with shortened timing parameters.
module tb_ultrasonic_scheduler;

    localparam int N    = 4;
    localparam int TRIG = 5;
    localparam int TDIV = 10;
    localparam int RTO  = 300;
    localparam int GAPC = 20;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         continuous = 1'b0;
    logic [N-1:0] echo = '0;
    logic [N-1:0] sensor_mask = '1;
    logic [N-1:0] trig;
    logic [7:0]   dist_value;
    logic [2:0]   dist_idx;
    logic         dist_err;
    logic         dist_valid;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int width [N];
    int dly   [N];
    int rem   [N];
    int tfall [N];
    logic [N-1:0] trig_prev = '0;
    logic [N-1:0] trig_seen = '0;

    int q_idx [$];
    int q_val [$];
    int q_err [$];
    int q_cyc [$];
    int q_echo[$];

    ultrasonic_scheduler #(
        .N_SENSORS   (N),
        .TRIG_CYCLES (TRIG),
        .TICK_DIV    (TDIV),
        .RISE_TIMEOUT(RTO),
        .GAP_CYCLES  (GAPC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef ULTRASONIC_MASK_EN
        .sensor_mask(sensor_mask),
`endif
        .start      (start),
        .continuous (continuous),
        .echo       (echo),
        .trig       (trig),
        .dist_value (dist_value),
        .dist_idx   (dist_idx),
        .dist_err   (dist_err),
        .dist_valid (dist_valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Strobe monitor first, then the sensor model, both on the falling edge.
    initial begin
        for (int k = 0; k < N; k++) begin
            width[k] = 0; dly[k] = 0; rem[k] = 0; tfall[k] = 0;
        end
        forever begin
            @(negedge clk);
            if (rst_n && dist_valid) begin
                q_idx.push_back(int'(dist_idx));
                q_val.push_back(int'(dist_value));
                q_err.push_back(int'(dist_err));
                q_cyc.push_back(cyc);
                q_echo.push_back(int'(echo[dist_idx[1:0]]));
            end
            trig_seen = trig_seen | trig;
            if (!rst_n) begin
                echo = '0;
                for (int k = 0; k < N; k++) begin dly[k] = 0; rem[k] = 0; end
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (trig_prev[k] && !trig[k]) begin
                        tfall[k] = cyc;
                        if (width[k] > 0) dly[k] = 2;
                    end
                    if (dly[k] > 0) begin
                        dly[k]--;
                        if (dly[k] == 0) begin
                            echo[k] = 1'b1;
                            rem[k]  = width[k];
                        end
                    end else if (rem[k] > 0) begin
                        rem[k]--;
                        if (rem[k] == 0) echo[k] = 1'b0;
                    end
                end
            end
            trig_prev = trig;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_widths(input int w0, input int w1, input int w2, input int w3);
        width[0] = w0; width[1] = w1; width[2] = w2; width[3] = w3;
    endtask

    task automatic clear_q();
        q_idx.delete(); q_val.delete(); q_err.delete(); q_cyc.delete(); q_echo.delete();
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_idle_in_budget"}, busy, 1'b0);
    endtask

    task automatic wait_strobes(input int count, input int budget, input string tag);
        int n = 0;
        while (q_idx.size() < count && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_strobes_in_budget"}, (q_idx.size() >= count), 1'b1);
    endtask

    function automatic int qi(input int i);
        return (i < q_idx.size()) ? q_idx[i] : -1;
    endfunction
    function automatic int qv(input int i);
        return (i < q_val.size()) ? q_val[i] : -1;
    endfunction
    function automatic int qe(input int i);
        return (i < q_err.size()) ? q_err[i] : -1;
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        check_eq("rst_trig", trig, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_valid", dist_valid, 0);
        check_eq("rst_value", dist_value, 0);
        rst_n = 1'b1;

        // Reset asserted while sensor 0 is being measured.
        set_widths(500, 0, 0, 0);
        clear_q();
        pulse_start();
        check_eq("start_busy", busy, 1);
        check_eq("start_trig", trig, 4'b0001);
        repeat (40) @(negedge clk);
        check_eq("mid_measure_echo", echo[0], 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_trig", trig, 0);
        check_eq("async_rst_busy", busy, 0);
        check_eq("async_rst_valid", dist_valid, 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (50) @(negedge clk);
        check_eq("post_rst_busy", busy, 0);
        check_eq("post_rst_trig", trig, 0);
        check_eq("post_rst_strobes", q_idx.size(), 0);

        // Plain scan: 100 high cycles = 10 cm on every sensor; a stray start is ignored.
        set_widths(100, 100, 100, 100);
        clear_q();
        pulse_start();
        repeat (200) @(negedge clk);
        pulse_start();
        wait_idle(3000, "scan");
        check_eq("scan_count", q_idx.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("scan_idx%0d", i), qi(i), i);
            check_eq($sformatf("scan_val%0d", i), qv(i), 10);
            check_eq($sformatf("scan_err%0d", i), qe(i), 0);
        end
        repeat (10) @(negedge clk);
        check_eq("scan_hold_value", dist_value, 10);
        check_eq("scan_hold_idx", dist_idx, 3);

        // Sensor 1 never answers.
        set_widths(100, 0, 30, 50);
        clear_q();
        pulse_start();
        wait_idle(4000, "timeout");
        check_eq("to_count", q_idx.size(), 4);
        check_eq("to_idx1", qi(1), 1);
        check_eq("to_val1", qv(1), 255);
        check_eq("to_err1", qe(1), 1);
        check_eq("to_latency", (q_cyc.size() > 1) ? q_cyc[1] - tfall[1] : -1, RTO);
        check_eq("to_val2", qv(2), 3);
        check_eq("to_err2", qe(2), 0);
        check_eq("to_val3", qv(3), 5);

        // Very long echo saturates before it falls.
        set_widths(2700, 100, 100, 100);
        clear_q();
        pulse_start();
        wait_idle(8000, "ovf");
        check_eq("ovf_idx0", qi(0), 0);
        check_eq("ovf_val0", qv(0), 255);
        check_eq("ovf_err0", qe(0), 1);
        check_eq("ovf_echo_still_high", (q_echo.size() > 0) ? q_echo[0] : -1, 1);
        check_eq("ovf_val1", qv(1), 10);
        repeat (200) @(negedge clk);

        // Width boundaries around one tick.
        set_widths(9, 10, 19, 20);
        clear_q();
        pulse_start();
        wait_idle(3000, "edge");
        check_eq("edge_w9", qv(0), 0);
        check_eq("edge_w9_err", qe(0), 0);
        check_eq("edge_w10", qv(1), 1);
        check_eq("edge_w19", qv(2), 1);
        check_eq("edge_w20", qv(3), 2);

        // Continuous mode dropped mid-scan finishes the scan in progress.
        set_widths(20, 20, 20, 20);
        clear_q();
        continuous = 1'b1;
        pulse_start();
        wait_strobes(6, 4000, "cont");
        continuous = 1'b0;
        wait_idle(3000, "cont");
        check_eq("cont_count", q_idx.size(), 8);
        check_eq("cont_idx4", qi(4), 0);
        check_eq("cont_last_idx", qi(7), 3);

`ifdef ULTRASONIC_MASK_EN
        sensor_mask = 4'b1010;
        clear_q();
        trig_seen = '0;
        continuous = 1'b1;
        pulse_start();
        wait_strobes(6, 4000, "mask");
        continuous = 1'b0;
        wait_idle(3000, "mask");
        for (int i = 0; i < 6; i++)
            check_eq($sformatf("mask_idx%0d", i), qi(i), (i % 2 == 0) ? 1 : 3);
        check_eq("mask_trig0_never", trig_seen[0], 0);
        check_eq("mask_trig2_never", trig_seen[2], 0);
        sensor_mask = 4'b0000;
        pulse_start();
        repeat (5) @(negedge clk);
        check_eq("mask_zero_busy", busy, 0);
        check_eq("mask_zero_trig", trig, 0);
        sensor_mask = 4'b1111;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation exceeded its time limit");
        $fatal(1);
    end

endmodule
